// File: rtl/neopix_tx.sv
// rtl/neopix_tx.sv - WS2812-style single-wire pixel transmitter
// Streams 24-bit GRB words MSB first as fixed-period pulses, then appends a latch gap.
module neopix_tx #(
  parameter int T0H     = 40,
  parameter int T1H     = 80,
  parameter int T_BIT   = 125,
  parameter int T_RESET = 8000,
  parameter int CNT_W   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] RST_END = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] HI0     = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI1     = CNT_W'(T1H);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic             last_q, last_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             pix_end;
  logic             xfer;

  // The final cycle of a non-last pixel doubles as the accept slot for its successor.
  assign pix_end   = (state_q == BIT) && (cnt_q == BIT_END) && (bit_idx_q == 5'd0);
  assign pix_ready = !rst && ((state_q == IDLE) || (pix_end && !last_q));
  assign xfer      = pix_valid && pix_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: ;
      BIT: begin
        if (cnt_q != BIT_END) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (bit_idx_q != 5'd0) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_idx_d = bit_idx_q - 5'd1;
          cnt_d     = '0;
        end else if (last_q) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else begin
          state_d    = IDLE;
          cnt_d      = '0;
          underrun_d = 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == RST_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer overrides both the IDLE hold and the underrun exit.
    if (xfer) begin
      state_d    = BIT;
      shift_d    = pix_data;
      bit_idx_d  = 5'd23;
      cnt_d      = '0;
      last_d     = pix_last;
      underrun_d = 1'b0;
    end

    dout_d = (state_d == BIT) && (cnt_d < (shift_d[23] ? HI1 : HI0));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_q     <= 1'b0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_neopix_tx.sv
// tb/tb_neopix_tx.sv - self-checking bench for neopix_tx
// Default and minimum-timing instances share one stimulus bus; a timeline model predicts every cycle.
module tb_neopix_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_last = 1'b0;
  logic        pix_valid = 1'b0;
  logic        rdy_a, dout_a, busy_a, und_a;
  logic        rdy_b, dout_b, busy_b, und_b;

  always #5 clk = ~clk;

  neopix_tx dut_a (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_last(pix_last), .pix_valid(pix_valid),
    .pix_ready(rdy_a), .dout(dout_a), .busy(busy_a), .underrun(und_a)
  );

  neopix_tx #(.T0H(1), .T1H(2), .T_BIT(3), .T_RESET(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_last(pix_last), .pix_valid(pix_valid),
    .pix_ready(rdy_b), .dout(dout_b), .busy(busy_b), .underrun(und_b)
  );

  typedef struct {
    string       name;
    int          sel;
    int          n;
    int          ab;
    logic [23:0] d0, d1;
    logic        l0, l1;
    int          g0, g1;
    int          exp_hi;
    int          exp_und;
  } vec_t;

  vec_t tbl[7];

  int errors = 0;
  int checks = 0;
  int t0h, t1h, tbit, trst;
  int np;
  logic [23:0] pd[8];
  logic        pl[8];
  int          pg[8];
  int          ps[8];

  task automatic chk(input string nm, input int c, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: dout/busy/ready/underrun got %b expected %b", nm, c, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Transfer cycle of each pixel, from presentation times and the protocol's accept rules.
  task automatic plan();
    int p;
    for (int k = 0; k < np; k++) begin
      p = (k == 0) ? pg[0] : ps[k-1] + 1 + pg[k];
      if (k == 0)
        ps[k] = p;
      else if (pl[k-1])
        ps[k] = (p > ps[k-1] + 24*tbit + trst) ? p : ps[k-1] + 24*tbit + trst + 1;
      else if (p <= ps[k-1] + 24*tbit)
        ps[k] = ps[k-1] + 24*tbit;
      else
        ps[k] = p;
    end
  endtask

  // Expected {dout, busy, pix_ready, underrun} during cycle c.
  function automatic logic [3:0] exp_at(input int c);
    for (int k = 0; k < np; k++) begin
      int t = c - ps[k];
      if (t >= 1 && t <= 24*tbit) begin
        int   b    = (t - 1) / tbit;
        int   w    = (t - 1) % tbit;
        logic bitv = pd[k][23-b];
        return {(w < (bitv ? t1h : t0h)), 1'b1, (t == 24*tbit && !pl[k]), 1'b0};
      end
    end
    for (int k = 0; k < np; k++) begin
      int t = c - ps[k];
      if (pl[k] && t > 24*tbit && t <= 24*tbit + trst) return 4'b0100;
    end
    for (int k = 0; k < np; k++)
      if (!pl[k] && c == ps[k] + 24*tbit + 1) return 4'b0011;
    return 4'b0010;
  endfunction

  task automatic run(input string nm, input int sel, input int ab, output int hi, output int und);
    int endc, k, acc_prev, p;
    logic [3:0] act, e;
    logic xf;
    t0h  = sel ? 1 : 40;
    t1h  = sel ? 2 : 80;
    tbit = sel ? 3 : 125;
    trst = sel ? 1 : 8000;
    plan();
    endc = ps[np-1] + 24*tbit + (pl[np-1] ? trst : 1) + 3;
    rst = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0; acc_prev = 0; hi = 0; und = 0;
    for (int c = 0; c <= endc; c++) begin
      p = (k == 0) ? pg[0] : acc_prev + 1 + ((k < np) ? pg[k] : 0);
      if (k < np && c >= p) begin
        pix_valid = 1'b1;
        pix_data  = pd[k];
        pix_last  = pl[k];
      end else begin
        pix_valid = 1'b0;
        pix_data  = 24'($urandom);
        pix_last  = 1'($urandom);
      end
      if (c == ab) rst = 1'b1;
      @(negedge clk);
      act = sel ? {dout_b, busy_b, rdy_b, und_b} : {dout_a, busy_a, rdy_a, und_a};
      if (c == ab)          e = exp_at(c) & 4'b1101;
      else if (c == ab + 1) e = 4'b0010;
      else                  e = exp_at(c);
      chk(nm, c, act, e);
      hi  += int'(act[3]);
      und += int'(act[0]);
      xf = pix_valid && act[1];
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (xf) begin
        acc_prev = c;
        k++;
      end
      if (ab >= 0 && c == ab + 1) break;
    end
    pix_valid = 1'b0;
  endtask

  task automatic add(input int i, input string nm, input int sel, input int n, input int ab,
                     input logic [23:0] d0, input logic l0, input int g0,
                     input logic [23:0] d1, input logic l1, input int g1,
                     input int ehi, input int eund);
    tbl[i].name = nm;  tbl[i].sel = sel; tbl[i].n = n;   tbl[i].ab = ab;
    tbl[i].d0 = d0;    tbl[i].l0 = l0;   tbl[i].g0 = g0;
    tbl[i].d1 = d1;    tbl[i].l1 = l1;   tbl[i].g1 = g1;
    tbl[i].exp_hi = ehi; tbl[i].exp_und = eund;
  endtask

  initial begin
    int hi, und;
    add(0, "rst_midbit", 0, 1, 656,  24'hFC0000, 1'b1, 0, 24'h0,      1'b0, 0,    431,  0);
    add(1, "single_ff",  0, 1, -1,   24'hFF0000, 1'b1, 0, 24'h0,      1'b0, 0,    1280, 0);
    add(2, "chain_aa55", 0, 2, -1,   24'hAAAAAA, 1'b0, 0, 24'h555555, 1'b1, 0,    2880, 0);
    add(3, "underrun",   0, 1, -1,   24'h000001, 1'b0, 0, 24'h0,      1'b0, 0,    1000, 1);
    add(4, "latch_wait", 0, 2, -1,   24'h000000, 1'b1, 0, 24'h00FF00, 1'b1, 3099, 2240, 0);
    add(5, "bnd_chain",  1, 2, -1,   24'hF0F0F0, 1'b0, 0, 24'h0F0F0F, 1'b1, 0,    72,   0);
    add(6, "bnd_late",   1, 2, -1,   24'h800001, 1'b0, 0, 24'h000000, 1'b1, 72,   50,   1);

    // Reset state, with valid asserted during reset to show reset wins.
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = 24'hFFFFFF;
    pix_last = 1'b1;
    @(negedge clk);
    chk("reset_a", 0, {dout_a, busy_a, rdy_a, und_a}, 4'b0000);
    chk("reset_b", 0, {dout_b, busy_b, rdy_b, und_b}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_a", 1, {dout_a, busy_a, rdy_a, und_a}, 4'b0010);
    chk("post_reset_b", 1, {dout_b, busy_b, rdy_b, und_b}, 4'b0010);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      np = tbl[i].n;
      pd[0] = tbl[i].d0; pl[0] = tbl[i].l0; pg[0] = tbl[i].g0;
      pd[1] = tbl[i].d1; pl[1] = tbl[i].l1; pg[1] = tbl[i].g1;
      run(tbl[i].name, tbl[i].sel, tbl[i].ab, hi, und);
      chk_int({tbl[i].name, "_high_cycles"}, hi, tbl[i].exp_hi);
      chk_int({tbl[i].name, "_underruns"}, und, tbl[i].exp_und);
    end

    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(1, 8);
      for (int k = 0; k < np; k++) begin
        pd[k] = 24'($urandom);
        pl[k] = 1'($urandom);
        pg[k] = $urandom_range(0, 80);
      end
      run("rand_bnd", 1, -1, hi, und);
    end

    np = 2;
    for (int k = 0; k < 2; k++) begin
      pd[k] = 24'($urandom);
      pl[k] = 1'($urandom);
      pg[k] = (k == 0) ? 0 : $urandom_range(0, 3100);
    end
    run("rand_full", 0, -1, hi, und);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
